// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: shared quarter/half-frame timebase with $4017 mode control.
// Define APU_FRAME_IRQ_EN to build the frame IRQ flag, IRQ inhibit and $4015 read-clear.
module apu_frame_sequencer #(
    parameter int STEP1    = 7457,
    parameter int STEP2    = 14913,
    parameter int STEP3    = 22371,
    parameter int STEP4    = 29829,
    parameter int STEP5    = 37281,
    parameter int WR_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_ce,
    input  logic       wr_4017,
    input  logic [7:0] wr_data,
    input  logic       rd_4015,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq
);

    localparam logic [15:0] S1 = 16'(STEP1);
    localparam logic [15:0] S2 = 16'(STEP2);
    localparam logic [15:0] S3 = 16'(STEP3);
    localparam logic [15:0] S4 = 16'(STEP4);
    localparam logic [15:0] S5 = 16'(STEP5);
    localparam logic [2:0]  WD = 3'(WR_DELAY);

    logic [15:0] cnt;
    logic        mode;
    logic        pmode;
    logic        pend;
    logic [2:0]  dly;

    logic        restart_tick;
    logic        at_wrap;
    logic        step_q;
    logic        step_h;

    // The wrap step is always a quarter+half event: STEP4 in 4-step mode, STEP5 in 5-step mode.
    always_comb begin
        restart_tick = apu_ce && pend && (dly == 3'd1);
        at_wrap      = (cnt == (mode ? S5 : S4));
        step_q       = (cnt == S1) || (cnt == S2) || (cnt == S3) || at_wrap;
        step_h       = (cnt == S2) || at_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 16'd0;
            mode          <= 1'b0;
            pmode         <= 1'b0;
            pend          <= 1'b0;
            dly           <= 3'd0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
            if (restart_tick) begin
                cnt           <= 16'd0;
                mode          <= pmode;
                pend          <= 1'b0;
                quarter_frame <= pmode;
                half_frame    <= pmode;
            end else if (apu_ce) begin
                quarter_frame <= step_q;
                half_frame    <= step_h;
                cnt           <= at_wrap ? 16'd0 : cnt + 16'd1;
                if (pend) begin
                    dly <= dly - 3'd1;
                end
            end
            // A write reloads the delay last so it beats any same-cycle decrement or restart.
            if (wr_4017) begin
                pmode <= wr_data[7];
                pend  <= 1'b1;
                dly   <= WD;
            end
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic inhibit;
    logic irq;
    logic irq_set;
    logic unused_bits;

    assign irq_set     = apu_ce && !restart_tick && !mode && (cnt == S4) && !inhibit;
    assign unused_bits = ^wr_data[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inhibit <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_4017) begin
                inhibit <= wr_data[6];
            end
            if (wr_4017 && wr_data[6]) begin
                irq <= 1'b0;
            end else if (irq_set) begin
                irq <= 1'b1;
            end else if (rd_4015) begin
                irq <= 1'b0;
            end
        end
    end

    assign frame_irq = irq;
`else
    logic unused_bits;

    assign unused_bits = ^{rd_4015, wr_data[6:0]};
    assign frame_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized/directed bench for apu_frame_sequencer: a default-timing instance and a short-timebase
// instance share one stimulus stream and are each checked against a tick-level behavioural model.
module tb_apu_frame_sequencer;

    typedef struct {
        int pos;
        bit mode;
        bit pmode;
        bit pend;
        int left;
        bit inhibit;
        bit irq;
        bit q;
        bit h;
    } model_t;

    localparam int DLY = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       apu_ce = 1'b0;
    logic       wr_4017 = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_4015 = 1'b0;

    logic q_s, h_s, irq_s;
    logic q_f, h_f, irq_f;

    int checks = 0;
    int errors = 0;
    int small_st[5];
    int full_st[5];
    model_t ms;
    model_t mf;

    always #5 clk = ~clk;

    apu_frame_sequencer #(
        .STEP1(37), .STEP2(73), .STEP3(111), .STEP4(149), .STEP5(186), .WR_DELAY(DLY)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .apu_ce(apu_ce), .wr_4017(wr_4017), .wr_data(wr_data),
        .rd_4015(rd_4015), .quarter_frame(q_s), .half_frame(h_s), .frame_irq(irq_s)
    );

    apu_frame_sequencer dut_f (
        .clk(clk), .rst_n(rst_n), .apu_ce(apu_ce), .wr_4017(wr_4017), .wr_data(wr_data),
        .rd_4015(rd_4015), .quarter_frame(q_f), .half_frame(h_f), .frame_irq(irq_f)
    );

    function automatic void model_reset(output model_t s);
        s.pos = 0; s.mode = 0; s.pmode = 0; s.pend = 0; s.left = 0;
        s.inhibit = 0; s.irq = 0; s.q = 0; s.h = 0;
    endfunction

    // One clk of the frame sequencer, described in terms of position within the frame period.
    function automatic void model_step(inout model_t s, input int st[5], input bit ce, input bit wr,
                                       input logic [7:0] d, input bit rd);
        bit set_irq = 0;
        int period;
        s.q = 0;
        s.h = 0;
        if (ce) begin
            if (s.pend && s.left == 1) begin
                s.pos  = 0;
                s.mode = s.pmode;
                s.pend = 0;
                s.q    = s.pmode;
                s.h    = s.pmode;
            end else begin
                if (s.pos == st[0] || s.pos == st[2]) s.q = 1;
                if (s.pos == st[1]) begin s.q = 1; s.h = 1; end
                if (!s.mode && s.pos == st[3]) begin s.q = 1; s.h = 1; set_irq = !s.inhibit; end
                if (s.mode && s.pos == st[4]) begin s.q = 1; s.h = 1; end
                period = (s.mode ? st[4] : st[3]) + 1;
                s.pos  = (s.pos + 1) % period;
                if (s.pend) s.left = s.left - 1;
            end
        end
`ifdef APU_FRAME_IRQ_EN
        if (wr && d[6]) s.irq = 0;
        else if (set_irq) s.irq = 1;
        else if (rd) s.irq = 0;
        if (wr) s.inhibit = d[6];
`else
        if (set_irq || rd) s.irq = 0;
`endif
        if (wr) begin
            s.pmode = d[7];
            s.pend  = 1;
            s.left  = DLY;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("small_quarter", q_s, ms.q);
        checkOutput("small_half", h_s, ms.h);
        checkOutput("small_irq", irq_s, ms.irq);
        checkOutput("full_quarter", q_f, mf.q);
        checkOutput("full_half", h_f, mf.h);
        checkOutput("full_irq", irq_f, mf.irq);
    endtask

    task automatic applyStimulus(input bit ce, input bit wr, input logic [7:0] d, input bit rd);
        @(negedge clk);
        apu_ce  = ce;
        wr_4017 = wr;
        wr_data = d;
        rd_4015 = rd;
        @(posedge clk);
        #1;
        model_step(ms, small_st, ce, wr, d, rd);
        model_step(mf, full_st, ce, wr, d, rd);
        apu_ce  = 1'b0;
        wr_4017 = 1'b0;
        rd_4015 = 1'b0;
        checkAll();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Reset lands between clock edges so the asynchronous clear is observed directly.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset(ms);
        model_reset(mf);
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        small_st = '{37, 73, 111, 149, 186};
        full_st  = '{7457, 14913, 22371, 29829, 37281};
        model_reset(ms);
        model_reset(mf);
        doReset();

        // Full 4-step frame plus the first quarter of the next; reads collide with STEP4 sets.
        for (int i = 0; i < 37290; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00,
                          (i == 29829) || (i == 29835) || (i == 149) || (i == 160));
        end

        for (int i = 0; i < 400 && !ms.irq; i++) runTicks(1);
`ifdef APU_FRAME_IRQ_EN
        checkOutput("irq_before_inhibit", irq_s, 1'b1);
`endif
        applyStimulus(1'b1, 1'b1, 8'h40, 1'b0);
        runTicks(400);

        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0);
        runTicks(400);
        applyStimulus(1'b1, 1'b1, 8'hC0, 1'b0);
        runTicks(200);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        runTicks(200);

        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        runTicks(2);
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0);
        runTicks(300);

        applyStimulus(1'b0, 1'b1, 8'h80, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        doReset();
        runTicks(200);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                          8'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
